pdt_weight_ctrl: RTL

Sequencer for the weight-prediction datapath (three candidate weights, their products, clipped weight update). Per band it reads the stored weight from the weight RAM and flags the first sample for recovery. It then issues samples at the hazard-safe rate and drives the one-hot update selector from the downstream comparator. At band end it writes the final weight back to the RAM.

---
 rtl/pdt_ctrl_pkg.sv | 32 +++
 rtl/pdt_ctrl_cnt.sv | 44 ++++
 rtl/pdt_weight_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pdt_ctrl_pkg.sv
// Shared types and encodings for the weight-prediction sequencer.
package pdt_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRdWait,
    StIssue,
    StGap,
    StWb
  } state_e;

  localparam logic [2:0] VEC_HOLD = 3'b001;
  localparam logic [2:0] VEC_ADD  = 3'b010;
  localparam logic [2:0] VEC_SUB  = 3'b100;

  // Comparator index to one-hot update select; the illegal index 3 falls back to hold.
  function automatic logic [2:0] sel_to_vec(input logic [1:0] idx);
    logic [2:0] vec;
    case (idx)
      2'd1:    vec = VEC_ADD;
      2'd2:    vec = VEC_SUB;
      default: vec = VEC_HOLD;
    endcase
    return vec;
  endfunction

  function automatic logic sel_illegal(input logic [1:0] idx);
    return idx == 2'd3;
  endfunction

endpackage

// File: rtl/pdt_ctrl_cnt.sv
// Sample and band counters for the weight sequencer, with terminal-count flags.
module pdt_ctrl_cnt #(
  parameter int unsigned BAND_LEN  = 1024,
  parameter int unsigned NUM_BANDS = 16,
  parameter int unsigned BAND_AW   = 4,
  parameter int unsigned CNT_W     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               smp_inc_i,
  input  logic               smp_clr_i,
  input  logic               band_inc_i,
  input  logic               band_clr_i,
  output logic               smp_last_o,
  output logic [BAND_AW-1:0] band_o,
  output logic               band_last_o
);

  logic [CNT_W-1:0]   smp_q;
  logic [BAND_AW-1:0] band_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      smp_q  <= '0;
      band_q <= '0;
    end else begin
      if (smp_clr_i) begin
        smp_q <= '0;
      end else if (smp_inc_i) begin
        smp_q <= smp_q + CNT_W'(1);
      end
      if (band_clr_i) begin
        band_q <= '0;
      end else if (band_inc_i) begin
        band_q <= band_q + BAND_AW'(1);
      end
    end
  end

  assign smp_last_o  = (smp_q == CNT_W'(BAND_LEN - 1));
  assign band_o      = band_q;
  assign band_last_o = (band_q == BAND_AW'(NUM_BANDS - 1));

endmodule

// File: rtl/pdt_weight_ctrl.sv
// Weight-prediction sequencer: per band restores the weight from RAM, issues samples
// one per two cycles, steers the update select, and writes the final weight back.
module pdt_weight_ctrl
  import pdt_ctrl_pkg::*;
#(
  parameter int unsigned BAND_LEN  = 1024,
  parameter int unsigned NUM_BANDS = 16,
  parameter int unsigned BAND_AW   = 4,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               smp_valid_i,
  output logic               smp_ready_o,
  input  logic               sel_valid_i,
  input  logic [1:0]         sel_idx_i,
  output logic               dn_en_o,
  output logic               recover_en_o,
  output logic [2:0]         vec_num_o,
  input  logic               crt_en_i,
  output logic               wram_rd_en_o,
  output logic [BAND_AW-1:0] wram_rd_addr_o,
  output logic               wram_wr_en_o,
  output logic [BAND_AW-1:0] wram_wr_addr_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e             state_q;
  logic               first_q;
  logic               last_q;
  logic [LAT_W-1:0]   lat_q;
  logic [2:0]         vec_num_q;
  logic               rd_en_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic               in_issue;
  logic               in_wb;
  logic               accept;
  logic               smp_last;
  logic               band_last;
  logic [BAND_AW-1:0] band;

  assign in_issue = (state_q == StIssue);
  assign in_wb    = (state_q == StWb);

  // The comparator result gates readiness so a sample never enters without its select.
  assign smp_ready_o  = in_issue & sel_valid_i;
  assign accept       = smp_ready_o & smp_valid_i;
  assign dn_en_o      = accept;
  assign recover_en_o = in_issue & first_q;

  assign wram_rd_en_o   = rd_en_q;
  assign wram_rd_addr_o = band;
  assign wram_wr_en_o   = in_wb & crt_en_i;
  assign wram_wr_addr_o = band;

  assign vec_num_o = vec_num_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

  pdt_ctrl_cnt #(
    .BAND_LEN  (BAND_LEN),
    .NUM_BANDS (NUM_BANDS),
    .BAND_AW   (BAND_AW),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .smp_inc_i   (accept),
    .smp_clr_i   (in_wb),
    .band_inc_i  (in_wb & ~band_last),
    .band_clr_i  (in_wb & band_last),
    .smp_last_o  (smp_last),
    .band_o      (band),
    .band_last_o (band_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      lat_q     <= '0;
      vec_num_q <= VEC_HOLD;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StRd;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
          end
        end
        StRd: begin
          first_q <= 1'b1;
          lat_q   <= LAT_W'(RD_LAT - 1);
          state_q <= StRdWait;
        end
        StRdWait: begin
          if (lat_q == '0) begin
            state_q <= StIssue;
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end
        StIssue: begin
          if (accept) begin
            vec_num_q <= sel_to_vec(sel_idx_i);
            if (sel_illegal(sel_idx_i)) begin
              err_q <= 1'b1;
            end
            first_q <= 1'b0;
            last_q  <= smp_last;
            state_q <= StGap;
          end
        end
        // Datapath consumes vec_num_o here; no accept keeps the weight update hazard-free.
        StGap: begin
          state_q <= last_q ? StWb : StIssue;
        end
        StWb: begin
          last_q <= 1'b0;
          if (!crt_en_i) begin
            err_q <= 1'b1;
          end
          if (band_last) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= StRd;
            rd_en_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
